// File: rtl/trigger_delay_cmd_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : trigger_delay_cmd_master_if
// Purpose  : Command request / response bundle for trigger_delay_cmd_master.
// Revision : 1.0 - initial release
// ============================================================================
interface trigger_delay_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_len;
  logic        rsp_timeout;
  logic        busy;

  modport master (
    output cmd_valid, cmd_op, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_len, rsp_timeout, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_len, rsp_timeout, busy
  );
endinterface
`default_nettype wire

// File: rtl/trigger_delay_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : trigger_delay_cmd_master
// Purpose  : UART command initiator: sends opcode + LSB-first args, gathers reply.
//            Define DELAY_CMD_TIMEOUT_EN to add the response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module trigger_delay_cmd_master #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD_RATE      = 115200,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  trigger_delay_cmd_master_if.slave   cmd,
  output logic                        uart_tx,
  input  logic                        uart_rx
);
  localparam int            CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int            CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF     = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] OP_SET_COARSE = 3'd0;
  localparam logic [2:0] OP_GET_COARSE = 3'd1;
  localparam logic [2:0] OP_SET_EDGE   = 3'd2;
  localparam logic [2:0] OP_GET_EDGE   = 3'd3;
  localparam logic [2:0] OP_GET_STATUS = 3'd4;
  localparam logic [2:0] OP_SET_FINE   = 3'd6;
  localparam logic [2:0] OP_GET_FINE   = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_DRAIN, S_RECV, S_DONE} state_t;

  state_t        r_state, w_next;
  logic          w_tx_en, w_tx_ready, w_accept, w_rx_take, w_expired;
  logic [7:0]    w_tx_data;
  logic [2:0]    w_tx_args;
  logic [3:0]    w_rx_bytes;
  logic [2:0]    r_op, r_tx_idx;
  logic [31:0]   r_wdata;
  logic          r_guard, r_rsp_timeout;
  logic [63:0]   r_rsp_data;
  logic [3:0]    r_rsp_len;

  // ---------------- UART transmitter (8N1) ----------------
  logic          r_tx_busy;
  logic [9:0]    r_tx_shift;
  logic [3:0]    r_tx_bits;
  logic [CW-1:0] r_tx_cnt;

  assign w_tx_ready = ~r_tx_busy;
  assign uart_tx    = r_tx_busy ? r_tx_shift[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_busy  <= 1'b0;
      r_tx_shift <= '1;
      r_tx_bits  <= '0;
      r_tx_cnt   <= '0;
    end else if (!r_tx_busy) begin
      if (w_tx_en) begin
        r_tx_busy  <= 1'b1;
        r_tx_shift <= {1'b1, w_tx_data, 1'b0};
        r_tx_bits  <= 4'd9;
        r_tx_cnt   <= BIT_LAST;
      end
    end else if (r_tx_cnt != '0) begin
      r_tx_cnt <= r_tx_cnt - 1'b1;
    end else if (r_tx_bits == '0) begin
      r_tx_busy <= 1'b0;
    end else begin
      r_tx_shift <= {1'b1, r_tx_shift[9:1]};
      r_tx_bits  <= r_tx_bits - 4'd1;
      r_tx_cnt   <= BIT_LAST;
    end
  end

  // ---------------- UART receiver, mid-bit sampling ----------------
  logic          r_rx_meta, r_rx_sync, r_rx_active, r_rx_valid;
  logic [3:0]    r_rx_bit;
  logic [CW-1:0] r_rx_cnt;
  logic [7:0]    r_rx_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_active <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_bit    <= '0;
      r_rx_cnt    <= '0;
      r_rx_data   <= '0;
    end else begin
      r_rx_meta  <= uart_rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_valid <= 1'b0;
      if (!r_rx_active) begin
        if (!r_rx_sync) begin
          r_rx_active <= 1'b1;
          r_rx_cnt    <= BIT_HALF;
          r_rx_bit    <= '0;
        end
      end else if (r_rx_cnt != '0) begin
        r_rx_cnt <= r_rx_cnt - 1'b1;
      end else begin
        r_rx_cnt <= BIT_LAST;
        if (r_rx_bit == 4'd0) begin
          // a start bit that is gone by mid-bit was a glitch
          if (r_rx_sync) r_rx_active <= 1'b0;
          r_rx_bit <= 4'd1;
        end else if (r_rx_bit == 4'd9) begin
          r_rx_active <= 1'b0;
          r_rx_valid  <= r_rx_sync;
        end else begin
          r_rx_data <= {r_rx_sync, r_rx_data[7:1]};
          r_rx_bit  <= r_rx_bit + 4'd1;
        end
      end
    end
  end

  // ---------------- command sequencer ----------------
  always_comb begin
    w_tx_args  = 3'd0;
    w_rx_bytes = 4'd0;
    case (r_op)
      OP_SET_COARSE: w_tx_args  = 3'd4;
      OP_GET_COARSE: w_rx_bytes = 4'd4;
      OP_SET_EDGE:   w_tx_args  = 3'd1;
      OP_GET_EDGE:   w_rx_bytes = 4'd1;
      OP_GET_STATUS: w_rx_bytes = 4'd8;
      OP_SET_FINE:   w_tx_args  = 3'd2;
      OP_GET_FINE:   w_rx_bytes = 4'd2;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_tx_en   = 1'b0;
    w_tx_data = (r_tx_idx == 3'd0) ? {5'd0, r_op} : r_wdata[7:0];
    w_accept  = 1'b0;
    w_rx_take = 1'b0;
    case (r_state)
      S_IDLE:  if (cmd.cmd_valid) begin
                 w_accept = 1'b1;
                 w_next   = S_SEND;
               end
      S_SEND:  if (w_tx_ready && !r_guard) begin
                 w_tx_en = 1'b1;
                 if (r_tx_idx == w_tx_args) w_next = S_DRAIN;
               end
      S_DRAIN: if (!r_guard && w_tx_ready)
                 w_next = (w_rx_bytes != 4'd0) ? S_RECV : S_DONE;
      S_RECV:  if (r_rx_valid) begin
                 w_rx_take = 1'b1;
                 if (r_rsp_len + 4'd1 == w_rx_bytes) w_next = S_DONE;
               end else if (w_expired) begin
                 w_next = S_DONE;
               end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op          <= '0;
      r_wdata       <= '0;
      r_tx_idx      <= '0;
      r_guard       <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_len     <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      // guard holds off the next byte until the transmitter has visibly gone busy
      if (w_tx_en)          r_guard <= 1'b1;
      else if (!w_tx_ready) r_guard <= 1'b0;
      if (w_accept) begin
        r_op          <= cmd.cmd_op;
        r_wdata       <= cmd.cmd_wdata;
        r_tx_idx      <= '0;
        r_rsp_data    <= '0;
        r_rsp_len     <= '0;
        r_rsp_timeout <= 1'b0;
      end
      if (w_tx_en) begin
        r_tx_idx <= r_tx_idx + 3'd1;
        if (r_tx_idx != 3'd0) r_wdata <= r_wdata >> 8;
      end
      if (w_rx_take) begin
        r_rsp_data[{r_rsp_len[2:0], 3'b000} +: 8] <= r_rx_data;
        r_rsp_len <= r_rsp_len + 4'd1;
      end
      if (r_state == S_RECV && !r_rx_valid && w_expired) r_rsp_timeout <= 1'b1;
    end
  end

`ifdef DELAY_CMD_TIMEOUT_EN
  logic [31:0] r_wdog;

  always_ff @(posedge clk) begin
    if (rst)
      r_wdog <= '0;
    else if ((r_state == S_DRAIN && w_next == S_RECV) || w_rx_take)
      r_wdog <= 32'(TIMEOUT_CYCLES);
    else if (r_state == S_RECV && r_wdog != '0)
      r_wdog <= r_wdog - 32'd1;
  end

  assign w_expired = (r_wdog == '0);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign w_expired          = 1'b0;
`endif

  assign cmd.cmd_ready   = (r_state == S_IDLE);
  assign cmd.busy        = (r_state != S_IDLE);
  assign cmd.rsp_valid   = (r_state == S_DONE);
  assign cmd.rsp_data    = r_rsp_data;
  assign cmd.rsp_len     = r_rsp_len;
  assign cmd.rsp_timeout = r_rsp_timeout;
endmodule
`default_nettype wire

// File: tb/tb_trigger_delay_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for trigger_delay_cmd_master: a behavioural remote delay unit on the UART
// lines, plus shadow registers predicting each response.
module tb_trigger_delay_cmd_master;
  localparam int CLK_FREQ = 100_000_000;
  localparam int BIT      = 16;
  localparam int TMO      = 3000;
  localparam int BUDGET   = 8000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trigger_delay_cmd_master_if bus ();
  logic uart_tx;
  logic remote_line = 1'b1;
  logic stray_line  = 1'b1;
  wire  uart_rx     = remote_line & stray_line;

  trigger_delay_cmd_master #(
    .CLK_FREQ       (CLK_FREQ),
    .BAUD_RATE      (CLK_FREQ / BIT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (bus),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx)
  );

  int TX_N [8] = '{4, 0, 1, 0, 0, 0, 2, 0};
  int RX_N [8] = '{0, 4, 0, 1, 8, 0, 0, 2};

  int total = 0;
  int bad   = 0;

  logic [7:0]  line_q [$];
  int          trig_total  = 0;
  logic        remote_live = 1'b1;
  logic [31:0] rm_coarse = '0, sh_coarse = '0;
  logic [7:0]  rm_edge   = '0, sh_edge   = '0;
  logic [15:0] rm_fine   = '0, sh_fine   = '0;
  int          rm_offset = 0,  sh_offset = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_frame(output logic [7:0] d, output logic ok, input bit bounded);
    int w;
    w  = 0;
    d  = '0;
    ok = 1'b0;
    while (uart_tx !== 1'b0) begin
      @(posedge clk);
      w++;
      if (bounded && w > 30 * BIT) return;
    end
    repeat (BIT / 2) @(posedge clk);
    if (uart_tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(posedge clk);
      d[i] = uart_tx;
    end
    repeat (BIT) @(posedge clk);
    ok = (uart_tx === 1'b1);
  endtask

  task automatic remote_send(input logic [7:0] d);
    @(negedge clk) remote_line = 1'b0;
    repeat (BIT - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) remote_line = d[i];
      repeat (BIT - 1) @(negedge clk);
    end
    @(negedge clk) remote_line = 1'b1;
    repeat (BIT - 1) @(negedge clk);
  endtask

  task automatic stray_send(input logic [7:0] d);
    @(negedge clk) stray_line = 1'b0;
    repeat (BIT - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) stray_line = d[i];
      repeat (BIT - 1) @(negedge clk);
    end
    @(negedge clk) stray_line = 1'b1;
    repeat (BIT - 1) @(negedge clk);
  endtask

  // Remote delay unit: decodes a command frame, updates its registers, replies.
  initial begin : remote
    logic [7:0]  b, ab;
    logic [2:0]  op;
    logic [31:0] arg;
    logic [63:0] rsp;
    logic        ok, abort;
    forever begin
      rx_frame(b, ok, 1'b0);
      if (ok) begin
        line_q.push_back(b);
        op    = b[2:0];
        arg   = '0;
        abort = 1'b0;
        for (int i = 0; i < TX_N[op]; i++) begin
          if (!abort) begin
            rx_frame(ab, ok, 1'b1);
            if (!ok) abort = 1'b1;
            else begin
              line_q.push_back(ab);
              arg[8*i +: 8] = ab;
            end
          end
        end
        if (!abort) begin
          rsp = '0;
          case (op)
            3'd0: rm_coarse = arg;
            3'd1: rsp[31:0] = rm_coarse;
            3'd2: rm_edge = arg[7:0];
            3'd3: rsp[7:0] = rm_edge;
            3'd4: rsp = {rm_fine, rm_coarse, 16'(trig_total - rm_offset)};
            3'd5: rm_offset = trig_total;
            3'd6: rm_fine = arg[15:0];
            default: rsp[15:0] = rm_fine;
          endcase
          if (remote_live && RX_N[op] > 0) begin
            repeat (2 * BIT) @(posedge clk);
            for (int i = 0; i < RX_N[op]; i++) remote_send(rsp[8*i +: 8]);
          end
        end
      end
    end
  end

  task automatic do_cmd(input logic [2:0] op, input logic [31:0] wd, input bit silent);
    int          start, lat, n;
    logic [63:0] exp_data;
    logic [39:0] exp_line, got_line;
    start = line_q.size();
    lat   = 0;
    @(negedge clk);
    while (!bus.cmd_ready && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_wdata = wd;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("rsp_valid_op%0d", op), bus.rsp_valid, 1'b1);
    if (bus.rsp_valid !== 1'b1) return;

    exp_data = '0;
    case (op)
      3'd0: sh_coarse = wd;
      3'd1: exp_data = {32'd0, sh_coarse};
      3'd2: sh_edge = wd[7:0];
      3'd3: exp_data = {56'd0, sh_edge};
      3'd4: exp_data = {sh_fine, sh_coarse, 16'(trig_total - sh_offset)};
      3'd5: sh_offset = trig_total;
      3'd6: sh_fine = wd[15:0];
      default: exp_data = {48'd0, sh_fine};
    endcase
    if (silent) exp_data = '0;
    chk($sformatf("rsp_data_op%0d", op), bus.rsp_data, exp_data);
    chk($sformatf("rsp_len_op%0d", op), 64'(bus.rsp_len), silent ? 64'd0 : 64'(RX_N[op]));
    chk($sformatf("rsp_timeout_op%0d", op), bus.rsp_timeout, silent);
    if (silent) chk("timeout_latency", lat >= TMO, 1'b1);

    n        = line_q.size() - start;
    exp_line = {wd, 5'd0, op};
    for (int i = 0; i < 5; i++) if (i > TX_N[op]) exp_line[8*i +: 8] = 8'h00;
    got_line = '0;
    for (int i = 0; i < n && i < 5; i++) got_line[8*i +: 8] = line_q[start + i];
    chk($sformatf("line_count_op%0d", op), 64'(n), 64'(1 + TX_N[op]));
    chk($sformatf("line_bytes_op%0d", op), 64'(got_line), 64'(exp_line));

    @(negedge clk);
    chk("rsp_valid_single_cycle", bus.rsp_valid, 1'b0);
    chk("rsp_data_hold", bus.rsp_data, exp_data);
    chk("ready_after_done", bus.cmd_ready, 1'b1);
  endtask

  initial begin : global_guard
    #3_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin : main
    int   start, lat;
    logic seen_valid, seen_low;
    logic [2:0] rop;

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_wdata = '0;
    repeat (4) @(negedge clk);
    chk("reset_cmd_ready", bus.cmd_ready, 1'b1);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_rsp_data", bus.rsp_data, 64'd0);
    chk("reset_rsp_len", 64'(bus.rsp_len), 64'd0);
    chk("reset_rsp_timeout", bus.rsp_timeout, 1'b0);
    chk("reset_uart_tx", uart_tx, 1'b1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    do_cmd(3'd0, 32'h1234_5678, 1'b0);
    do_cmd(3'd1, 32'h0, 1'b0);
    do_cmd(3'd6, 32'h0000_01F4, 1'b0);
    do_cmd(3'd2, 32'h0000_0002, 1'b0);
    trig_total += 6;
    do_cmd(3'd4, 32'h0, 1'b0);
    do_cmd(3'd3, 32'h0, 1'b0);
    do_cmd(3'd5, 32'h0, 1'b0);
    do_cmd(3'd4, 32'h0, 1'b0);

    // a byte arriving while idle must not leak into the next response
    stray_send(8'hA5);
    repeat (4) @(negedge clk);
    do_cmd(3'd7, 32'h0, 1'b0);

    // cmd_valid held for the whole transaction produces one command only
    start = line_q.size();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd3;
    bus.cmd_wdata = $urandom;
    repeat (3) @(negedge clk);
    chk("held_busy", bus.busy, 1'b1);
    chk("held_not_ready", bus.cmd_ready, 1'b0);
    lat = 0;
    while (!bus.rsp_valid && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    chk("held_rsp_valid", bus.rsp_valid, 1'b1);
    chk("held_rsp_data", bus.rsp_data, {56'd0, sh_edge});
    bus.cmd_valid = 1'b0;
    repeat (400) @(negedge clk);
    chk("held_single_cmd", 64'(line_q.size() - start), 64'd1);

    for (int k = 0; k < 16; k++) begin
      rop = 3'($urandom_range(0, 7));
      trig_total += $urandom_range(0, 5);
      do_cmd(rop, $urandom, 1'b0);
    end
    do_cmd(3'd4, 32'h0, 1'b0);

    // reset after the second byte of SET_COARSE
    start = line_q.size();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd0;
    bus.cmd_wdata = $urandom;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 0;
    while (line_q.size() < start + 2 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    chk("rst_mid_two_bytes", 64'(line_q.size() - start), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_uart_tx", uart_tx, 1'b1);
    chk("rst_mid_ready", bus.cmd_ready, 1'b1);
    rst        = 1'b0;
    seen_valid = 1'b0;
    seen_low   = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_valid = 1'b1;
      if (uart_tx !== 1'b1) seen_low = 1'b1;
    end
    chk("rst_mid_no_rsp", seen_valid, 1'b0);
    chk("rst_mid_no_tx", seen_low, 1'b0);
    do_cmd(3'd1, 32'h0, 1'b0);

`ifdef DELAY_CMD_TIMEOUT_EN
    remote_live = 1'b0;
    do_cmd(3'd7, 32'h0, 1'b1);
    remote_live = 1'b1;
    do_cmd(3'd7, 32'h0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
